// File: rtl/vram_write_scheduler.sv
// Queues tile updates and a whole-screen clear, and releases them to the VGA
// CPU write port only while the controller reports its vertical-blank window.
module vram_write_scheduler #(
  parameter int FIFO_DEPTH = 16,
  parameter int TILE_COUNT = 1200,
  parameter int ADDR_W     = 11
) (
  input  logic                         sys_clock,
  input  logic                         reset,
  input  logic                         upd_valid,
  output logic                         upd_ready,
  input  logic [ADDR_W-1:0]            upd_addr,
  input  logic [1:0]                   upd_data,
  input  logic                         clr_req,
  input  logic [1:0]                   clr_color,
  output logic                         clr_busy,
  input  logic                         vsync_ready,
  output logic                         cpu_we,
  output logic [ADDR_W-1:0]            cpu_addr,
  output logic [1:0]                   cpu_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_TILE = ADDR_W'(TILE_COUNT - 1);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DRAIN
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_W+1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]    level_reg;

  logic [ADDR_W-1:0]   sweep_reg;
  logic [1:0]          clr_color_reg;
  logic                clr_busy_reg;

  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [1:0]          data_reg;

  logic                fifo_full, fifo_empty, push, pop, clr_accept;
  logic [ADDR_W-1:0]   head_addr;
  logic [1:0]          head_data;
  logic                wr_en, sweep_step, clr_done;
  logic [ADDR_W-1:0]   wr_addr;
  logic [1:0]          wr_data;

  assign fifo_full  = (level_reg == FULL_LVL);
  assign fifo_empty = (level_reg == '0);
  assign push       = upd_valid && !fifo_full;
  assign clr_accept = clr_req && !clr_busy_reg;
  assign head_addr  = fifo_mem[rd_ptr_reg][ADDR_W+1:2];
  assign head_data  = fifo_mem[rd_ptr_reg][1:0];

  assign upd_ready  = !fifo_full;
  assign fifo_level = level_reg;
  assign clr_busy   = clr_busy_reg;
  assign cpu_we     = we_reg;
  assign cpu_addr   = addr_reg;
  assign cpu_data   = data_reg;

  always_ff @(posedge sys_clock) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = addr_reg;
    wr_data    = data_reg;
    sweep_step = 1'b0;
    clr_done   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (vsync_ready) begin
          if (clr_busy_reg)     state_next = ST_CLEAR;
          else if (!fifo_empty) state_next = ST_DRAIN;
        end
      end
      ST_CLEAR: begin
        if (!vsync_ready) begin
          state_next = ST_IDLE;
        end else begin
          wr_en      = 1'b1;
          wr_addr    = sweep_reg;
          wr_data    = clr_color_reg;
          sweep_step = 1'b1;
          if (sweep_reg == LAST_TILE) begin
            clr_done   = 1'b1;
            state_next = fifo_empty ? ST_IDLE : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // A pending clear takes over before the next pop, so every queued
        // update lands after the sweep and survives it.
        if (!vsync_ready) begin
          state_next = ST_IDLE;
        end else if (clr_busy_reg || clr_accept) begin
          state_next = ST_CLEAR;
        end else if (fifo_empty) begin
          state_next = ST_IDLE;
        end else begin
          pop     = 1'b1;
          wr_en   = (head_addr <= LAST_TILE);
          wr_addr = head_addr;
          wr_data = head_data;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (push) fifo_mem[wr_ptr_reg] <= {upd_addr, upd_data};
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      clr_busy_reg  <= 1'b0;
      clr_color_reg <= 2'b00;
      sweep_reg     <= '0;
    end else if (clr_accept) begin
      clr_busy_reg  <= 1'b1;
      clr_color_reg <= clr_color;
      sweep_reg     <= '0;
    end else if (clr_done) begin
      clr_busy_reg  <= 1'b0;
      sweep_reg     <= '0;
    end else if (sweep_step) begin
      sweep_reg     <= sweep_reg + ADDR_W'(1);
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      we_reg   <= 1'b0;
      addr_reg <= '0;
      data_reg <= 2'b00;
    end else begin
      we_reg   <= wr_en;
      addr_reg <= wr_addr;
      data_reg <= wr_data;
    end
  end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Scoreboard bench: stimulus queues the expected VRAM writes, a negedge monitor
// pops and compares every cpu_we strobe and keeps a VRAM model.
module tb_vram_write_scheduler;

  logic        sys_clock;
  logic        reset;
  logic        upd_valid;
  logic        upd_ready;
  logic [10:0] upd_addr;
  logic [1:0]  upd_data;
  logic        clr_req;
  logic [1:0]  clr_color;
  logic        clr_busy;
  logic        vsync_ready;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [1:0]  cpu_data;
  logic [4:0]  fifo_level;

  vram_write_scheduler #(
    .FIFO_DEPTH(16),
    .TILE_COUNT(1200),
    .ADDR_W(11)
  ) dut (
    .sys_clock(sys_clock),
    .reset(reset),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_addr(upd_addr),
    .upd_data(upd_data),
    .clr_req(clr_req),
    .clr_color(clr_color),
    .clr_busy(clr_busy),
    .vsync_ready(vsync_ready),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_data(cpu_data),
    .fifo_level(fifo_level)
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          run_len  = 0;
  logic [12:0] exp_q[$];
  logic [1:0]  vram [2048];

  always @(negedge sys_clock) begin
    logic [12:0] e;
    if (cpu_we) begin
      run_len++;
      vram[cpu_addr] = cpu_data;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr %0d data %0d, required no write", cpu_addr, cpu_data);
      end else begin
        e = exp_q.pop_front();
        if ({cpu_addr, cpu_data} === e) n_pass++;
        else $display("FAIL write_order: got addr %0d data %0d, required addr %0d data %0d",
                      cpu_addr, cpu_data, e[12:2], e[1:0]);
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic tick();
    @(negedge sys_clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic expect_write(input int a, input int d);
    logic [10:0] aa;
    logic [1:0]  dd;
    aa = 11'(a);
    dd = 2'(d);
    exp_q.push_back({aa, dd});
  endtask

  task automatic push(input int a, input int d, input bit enqueue);
    check("push_ready", upd_ready, 1);
    upd_valid = 1'b1;
    upd_addr  = 11'(a);
    upd_data  = 2'(d);
    tick();
    upd_valid = 1'b0;
    if (enqueue) expect_write(a, d);
  endtask

  task automatic clear_cmd(input int c);
    clr_req   = 1'b1;
    clr_color = 2'(c);
    tick();
    clr_req   = 1'b0;
    check("clr_busy_rise", clr_busy, 1);
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int others;
    reset = 1'b1; upd_valid = 1'b0; upd_addr = '0; upd_data = '0;
    clr_req = 1'b0; clr_color = '0; vsync_ready = 1'b0;
    for (int i = 0; i < 2048; i++) vram[i] = 2'b11;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state, then a long closed window
    check("rst_cpu_we", cpu_we, 0);
    check("rst_cpu_addr", cpu_addr, 0);
    check("rst_cpu_data", cpu_data, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_upd_ready", upd_ready, 1);
    repeat (100) tick();
    check("idle_upd_ready", upd_ready, 1);
    check("idle_fifo_level", fifo_level, 0);
    check("idle_clr_busy", clr_busy, 0);

    // Full clear with colour 00
    clear_cmd(0);
    for (int a = 0; a < 1200; a++) expect_write(a, 0);
    vsync_ready = 1'b1;
    for (int i = 0; i < 3000 && !(cpu_we && cpu_addr == 11'd1199); i++) tick();
    check("clr0_last_write", int'(cpu_we && cpu_addr == 11'd1199), 1);
    check("clr0_busy_fall", clr_busy, 0);
    check("clr0_run_len", run_len, 1200);
    vsync_ready = 1'b0;
    tick();
    check("clr0_drained", exp_q.size(), 0);

    // Ten updates queued outside the window
    for (int a = 565; a <= 573; a++) push(a, 1, 1'b1);
    push(575, 3, 1'b1);
    check("burst_level", fifo_level, 10);
    vsync_ready = 1'b1;
    tick();
    check("burst_lat_e1", cpu_we, 0);
    tick();
    check("burst_lat_e2", cpu_we, 1);
    drain("burst_drained", 50);
    check("burst_run_len", run_len, 10);
    check("burst_level_zero", fifo_level, 0);
    tick(); tick();

    // Push with the window open: write after edge E+2
    push(700, 2, 1'b1);
    check("open_lat_e0", cpu_we, 0);
    tick();
    check("open_lat_e1", cpu_we, 0);
    tick();
    check("open_lat_e2", cpu_we, 1);
    tick(); tick();

    // Out-of-range address is accepted then dropped
    push(1500, 1, 1'b0);
    push(701, 3, 1'b1);
    drain("oor_drained", 20);
    repeat (5) tick();
    check("oor_level", fifo_level, 0);
    vsync_ready = 1'b0;
    tick();

    // Fill the FIFO, reject a 17th update, then drain all 16
    for (int i = 0; i < 16; i++) push(100 + i, i % 4, 1'b1);
    check("full_level", fifo_level, 16);
    check("full_ready", upd_ready, 0);
    upd_valid = 1'b1; upd_addr = 11'd999; upd_data = 2'd3;
    tick();
    upd_valid = 1'b0;
    check("full_reject_level", fifo_level, 16);
    vsync_ready = 1'b1;
    drain("full_drained", 100);
    repeat (3) tick();
    check("full_level_zero", fifo_level, 0);
    vsync_ready = 1'b0;
    tick();

    // Clear interrupted after address 499, resumed next window
    clear_cmd(2);
    for (int a = 0; a < 1200; a++) expect_write(a, 2);
    vsync_ready = 1'b1;
    for (int i = 0; i < 1000 && !(cpu_we && cpu_addr == 11'd499); i++) tick();
    check("split_reach_499", int'(cpu_we && cpu_addr == 11'd499), 1);
    vsync_ready = 1'b0;
    repeat (20) tick();
    check("split_busy_held", clr_busy, 1);
    check("split_remaining", exp_q.size(), 700);
    vsync_ready = 1'b1;
    drain("split_drained", 2000);
    check("split_busy_fall", clr_busy, 0);
    vsync_ready = 1'b0;
    tick();

    // Update queued before a clear is written after the sweep
    push(600, 1, 1'b0);
    clear_cmd(0);
    for (int a = 0; a < 1200; a++) expect_write(a, 0);
    expect_write(600, 1);
    vsync_ready = 1'b1;
    drain("order_drained", 3000);
    repeat (3) tick();
    vsync_ready = 1'b0;
    check("order_tile600", vram[600], 1);
    others = 0;
    for (int a = 0; a < 1200; a++) if (a != 600 && vram[a] != 2'b00) others++;
    check("order_others_zero", others, 0);

    // Reset mid-operation discards queued updates and the pending clear
    push(10, 1, 1'b0);
    push(11, 2, 1'b0);
    clear_cmd(3);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("midrst_level", fifo_level, 0);
    check("midrst_busy", clr_busy, 0);
    check("midrst_ready", upd_ready, 1);
    vsync_ready = 1'b1;
    repeat (50) tick();
    vsync_ready = 1'b0;
    check("midrst_no_writes", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_write_scheduler.md
# vram_write_scheduler

Buffers tile updates from the game logic and issues them on the `vga_controller` CPU write port only while `vsync_ready` is high, so VRAM changes never tear a visible frame. Sits directly upstream of `vga_controller`: drives its `cpu_we`/`cpu_addr`/`cpu_data` and consumes its `vsync_ready`. Accepts single-tile updates through a valid/ready FIFO and a whole-screen clear command that sweeps every tile address.

## Interface

- `FIFO_DEPTH`, 16, update FIFO entries (power of two, ≥2)
- `TILE_COUNT`, 1200, tiles per screen (40×30)
- `ADDR_W`, 11, tile address width

- `sys_clock`  in  1  100 MHz system clock, single clock domain
- `reset`  in  1  synchronous, active-high
- `upd_valid`  in  1  update request
- `upd_ready`  out  1  update accepted when `upd_valid && upd_ready`
- `upd_addr`  in  ADDR_W  tile address, 0..TILE_COUNT-1
- `upd_data`  in  2  tile colour code
- `clr_req`  in  1  one-cycle clear request
- `clr_color`  in  2  clear colour, sampled with `clr_req`
- `clr_busy`  out  1  clear accepted and not yet finished
- `vsync_ready`  in  1  level from `vga_controller`, high during the vertical-blank write window
- `cpu_we`  out  1  VRAM write strobe
- `cpu_addr`  out  ADDR_W  VRAM write address
- `cpu_data`  out  2  VRAM write data
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation

- FIFO: `upd_ready` = !full (combinational). Updates with `upd_addr` ≥ TILE_COUNT are accepted, then dropped at pop (no write).
- Clear: `clr_req` accepted when `clr_busy`=0. It latches `clr_color`, sets `clr_busy`, and loads sweep counter to 0. A `clr_req` while `clr_busy`=1 is ignored.
- FSM states:
  - IDLE: no writes.
    - → CLEAR when `vsync_ready` && `clr_busy`.
    - → DRAIN when `vsync_ready` && FIFO non-empty.
    - CLEAR has priority over DRAIN.
  - CLEAR: one write per cycle at the counter address with `clr_color`, then counter +1.
    - After writing address TILE_COUNT-1: `clr_busy`←0, → DRAIN if FIFO non-empty, else IDLE.
    - `vsync_ready` low → IDLE; counter is held and the sweep resumes at the same address next window.
  - DRAIN: one FIFO pop and one write per cycle.
    - FIFO empty → IDLE.
    - `vsync_ready` low → IDLE.
    - A `clr_req` accepted mid-DRAIN → CLEAR next cycle; the remaining FIFO entries follow the sweep.
- Ordering: updates are written in push order. Updates pushed before or during a clear are still written after the sweep, so they are never erased.
- Simultaneous push and pop in the same cycle: `fifo_level` unchanged, both take effect.

## Timing

- Reset values:
  - `cpu_we`=0, `cpu_addr`=0, `cpu_data`=0, `clr_busy`=0, `fifo_level`=0.
  - FIFO empty, so `upd_ready`=1.
  - FSM in IDLE, sweep counter 0.
- Reset mid-operation discards FIFO contents and any pending or in-progress clear.
- `cpu_we`/`cpu_addr`/`cpu_data` are registered. The write decision at edge N uses `vsync_ready` sampled at N; the strobe is visible in cycle N..N+1.
- At most one write trails the falling edge of `vsync_ready`, by one cycle. This is permitted because it falls inside the back porch.
- First-write latency: a push at edge E with `vsync_ready` high and FSM IDLE gives `cpu_we`=1 in the cycle following edge E+2.
- Throughput: one write per cycle sustained in CLEAR and DRAIN.
- Full clear: exactly TILE_COUNT consecutive `cpu_we` cycles if the window holds, 12 µs of a ~1.4 ms vblank.
- `fifo_level` updates on the edge after push/pop. `upd_ready` falls in the same cycle `fifo_level` reaches FIFO_DEPTH.
- `clr_busy` rises on the edge after `clr_req`. It falls on the edge that issues the write to TILE_COUNT-1.

## Test plan

- Reset, hold `vsync_ready`=0 for 100 cycles → `cpu_we` stays 0, `upd_ready`=1, `fifo_level`=0, `clr_busy`=0.
- `clr_req` with colour 00, then raise `vsync_ready` → 1200 consecutive writes, addresses 0..1199 in order, data 00. `clr_busy` falls with the last write.
- Outside the window, push addresses 565..573 data 01 and 575 data 11, then raise `vsync_ready` → 10 back-to-back writes in that order, first at edge+2 latency, `fifo_level` returns to 0.
- Push 16 updates with `vsync_ready`=0 → `upd_ready`=0 at `fifo_level`=16. A 17th `upd_valid` is not accepted. In the next window all 16 are written, with no loss or duplication.
- Clear with colour 10, drop `vsync_ready` after the write to address 499 → writes stop with at most one trailing write. Next window resumes at address 500 (or 501 if the trailing write occurred), and the total writes equal 1200 with no gaps.
- Push update (600, 01), then `clr_req` colour 00, then open the window → 1200 clear writes, then the write of 600 data 01. Final VRAM model has tile 600 = 01, all others 00.
